// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad row scanner that locks onto a held key.
//   clk, reset  : system clock, synchronous active-high reset
//   col_n       : keypad columns, active-low, asynchronous to clk
//   row_n       : one-hot active-low row drive
//   key_pressed : high while a key is held on the locked row
//   key_code    : hex value of the last captured key
//   key_new     : one-cycle pulse when a key is captured
module keypad_scanner #(
  parameter int SCAN_DIV = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_pressed,
  output logic [3:0] key_code,
  output logic       key_new
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  // Nibble {row,col} holds that key's hex code; row 3 reads E,0,F,D from col0
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic {SCAN, HOLD} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    r_q, c;
  logic [3:0]    sync_q, col_s_q, row_q, code_q;
  logic          pressed_q, new_q, sample, idle;
  always_comb begin
    sample = cnt_q == LAST;
    idle   = &col_s_q;
    cnt_d  = sample ? '0 : cnt_q + 1'b1;
    c      = !col_s_q[0] ? 2'd0 : !col_s_q[1] ? 2'd1 : !col_s_q[2] ? 2'd2 : 2'd3;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      r_q       <= 2'd0;
      row_q     <= 4'b1110;
      sync_q    <= 4'b1111;
      col_s_q   <= 4'b1111;
      code_q    <= 4'h0;
      pressed_q <= 1'b0;
      new_q     <= 1'b0;
    end else begin
      sync_q  <= col_n;
      col_s_q <= sync_q;
      cnt_q   <= cnt_d;
      new_q   <= 1'b0;
      if (sample) begin
        // An all-idle row advances the scan from either state; a held key in HOLD changes nothing
        if (idle) begin
          state_q   <= SCAN;
          r_q       <= r_q + 2'd1;
          row_q     <= ~(4'b0001 << (r_q + 2'd1));
          pressed_q <= 1'b0;
        end else if (state_q == SCAN) begin
          state_q   <= HOLD;
          code_q    <= KEY_MAP[{r_q, c, 2'b00} +: 4];
          pressed_q <= 1'b1;
          new_q     <= 1'b1;
        end
      end
    end
  end
  assign row_n       = row_q;
  assign key_pressed = pressed_q;
  assign key_code    = code_q;
  assign key_new     = new_q;
endmodule
